// File: rtl/prog_counter_gen_if.sv
// Control and data bundle for prog_counter_gen.
// The master drives the counter commands and the slave returns the count and pad enables.
interface prog_counter_gen_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             load_e;
  logic [WIDTH-1:0] load_val;
  logic             dir;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] max_val;
  logic             out_e;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] out_oe;
  logic             tc;

  modport master (
    output en, load_e, load_val, dir, step, max_val, out_e,
    input  out_data, out_oe, tc
  );

  modport slave (
    input  en, load_e, load_val, dir, step, max_val, out_e,
    output out_data, out_oe, tc
  );
endinterface

// File: rtl/prog_counter_gen.sv
// Loadable up/down counter with runtime step and bound, wrap or saturate at the rails,
// a registered terminal-count pulse and per-bit pad output enables.
module prog_counter_gen #(
  parameter int WIDTH     = 8,
  parameter int RESET_VAL = 0,
  parameter int SATURATE  = 0
) (
  input  logic                clk,
  input  logic                reset,
  prog_counter_gen_if.slave   bus
);

  localparam int EW = WIDTH + 2;

  logic [WIDTH-1:0] r_count;
  logic             r_tc;

  logic [EW-1:0]    w_count;
  logic [EW-1:0]    w_step;
  logic [EW-1:0]    w_max;
  logic [EW-1:0]    w_maxPlus1;
  logic [EW-1:0]    w_sum;
  logic [EW-1:0]    w_upWrap;
  logic [EW-1:0]    w_downWrap;
  logic [WIDTH-1:0] w_next;
  logic             w_nextTc;

  // Two guard bits keep the wrap arithmetic exact and make a down-wrap underflow visible.
  assign w_count    = {2'b00, r_count};
  assign w_step     = {2'b00, bus.step};
  assign w_max      = {2'b00, bus.max_val};
  assign w_maxPlus1 = w_max + EW'(1);
  assign w_sum      = w_count + w_step;
  assign w_upWrap   = w_sum - w_maxPlus1;
  assign w_downWrap = w_count + w_maxPlus1 - w_step;

  always_comb begin
    w_next   = r_count;
    w_nextTc = 1'b0;
    if (bus.load_e) begin
      w_next = (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;
    end else if (bus.en && (bus.step != '0)) begin
      if (r_count > bus.max_val) begin
        w_next   = bus.dir ? '0 : bus.max_val;
        w_nextTc = 1'b1;
      end else if (bus.dir) begin
        if (w_sum <= w_max) begin
          w_next = w_sum[WIDTH-1:0];
        end else begin
          w_nextTc = 1'b1;
          // Clamps only matter for an illegal step; they keep the count inside the bound.
          if (SATURATE != 0)        w_next = bus.max_val;
          else if (w_upWrap > w_max) w_next = bus.max_val;
          else                       w_next = w_upWrap[WIDTH-1:0];
        end
      end else begin
        if (r_count >= bus.step) begin
          w_next = r_count - bus.step;
        end else begin
          w_nextTc = 1'b1;
          if (SATURATE != 0)          w_next = '0;
          else if (w_downWrap > w_max) w_next = '0;
          else                         w_next = w_downWrap[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= WIDTH'(RESET_VAL);
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_next;
      r_tc    <= w_nextTc;
    end
  end

  assign bus.out_data = r_count;
  assign bus.out_oe   = {WIDTH{bus.out_e}};
  assign bus.tc       = r_tc;

  // A step larger than the bound is a misuse of the counter.
  illegalStep: assert property (@(posedge clk) disable iff (reset)
                                (bus.en && !bus.load_e) |-> (bus.step <= bus.max_val));

endmodule
